// File: rtl/cabezal_corte.sv
// Cutting-head positioner: steps X/Y toward each latched target every DIVISOR cycles, dwells, then requests the next point.
// Optional feature macro CABEZAL_REGRESO_EN: the end-of-path marker first returns the head to (0,0), then finishes.
module cabezal_corte #(
    parameter int                    bits_eje      = 6,
    parameter int                    DIVISOR       = 4,
    parameter int                    TIEMPO_CORTE  = 2,
    parameter int                    LATENCIA_DATO = 4,
    parameter logic [2*bits_eje-1:0] MARCA_FIN     = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cortando,
    input  logic [bits_eje-1:0] x_objetivo,
    input  logic [bits_eje-1:0] y_objetivo,
    output logic [bits_eje-1:0] x_actual,
    output logic [bits_eje-1:0] y_actual,
    output logic                paso_x,
    output logic                paso_y,
    output logic                dir_x,
    output logic                dir_y,
    output logic                dato_siguiente,
    output logic                corte_terminado,
    output logic                en_movimiento,
    output logic [2:0]          estado_actual
);

    localparam int DW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int CMAX = (TIEMPO_CORTE > LATENCIA_DATO) ? TIEMPO_CORTE : LATENCIA_DATO;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        REPOSO       = 3'd0,
        CARGAR       = 3'd1,
        MOVER        = 3'd2,
        ASENTAR      = 3'd3,
        AVISAR       = 3'd4,
        ESPERAR_DATO = 3'd5,
        REGRESAR     = 3'd6,
        FIN          = 3'd7
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [DW-1:0]       div_q, div_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [bits_eje-1:0] x_q, x_d, y_q, y_d;
    logic [bits_eje-1:0] tx_q, tx_d, ty_q, ty_d;
    logic                dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic                paso_x_q, paso_x_d, paso_y_q, paso_y_d;

    logic [bits_eje-1:0] x_sig, y_sig;
    logic                mueve_x, mueve_y, en_destino;

    // Candidate position after one step; each axis only ever moves toward its latched target, so it cannot wrap.
    always_comb begin
        mueve_x = (x_q != tx_q);
        mueve_y = (y_q != ty_q);
        x_sig   = x_q;
        y_sig   = y_q;
        if (mueve_x) begin
            x_sig = dir_x_q ? (x_q + 1'b1) : (x_q - 1'b1);
        end
        if (mueve_y) begin
            y_sig = dir_y_q ? (y_q + 1'b1) : (y_q - 1'b1);
        end
        en_destino = (x_sig == tx_q) && (y_sig == ty_q);
    end

    always_comb begin
        estado_d = estado_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        paso_x_d = 1'b0;
        paso_y_d = 1'b0;

        case (estado_q)
            REPOSO: begin
                if (cortando) begin
                    estado_d = CARGAR;
                end
            end
            CARGAR: begin
                div_d   = '0;
                cnt_d   = '0;
                tx_d    = x_objetivo;
                ty_d    = y_objetivo;
                dir_x_d = (x_objetivo > x_q);
                dir_y_d = (y_objetivo > y_q);
                if ({x_objetivo, y_objetivo} == MARCA_FIN) begin
`ifdef CABEZAL_REGRESO_EN
                    tx_d    = '0;
                    ty_d    = '0;
                    dir_x_d = 1'b0;
                    dir_y_d = 1'b0;
                    estado_d = ((x_q == '0) && (y_q == '0)) ? FIN : REGRESAR;
`else
                    estado_d = FIN;
`endif
                end else if ((x_objetivo == x_q) && (y_objetivo == y_q)) begin
                    estado_d = AVISAR;
                end else begin
                    estado_d = MOVER;
                end
            end
            MOVER, REGRESAR: begin
                if (div_q == DW'(DIVISOR - 1)) begin
                    div_d    = '0;
                    paso_x_d = mueve_x;
                    paso_y_d = mueve_y;
                    x_d      = x_sig;
                    y_d      = y_sig;
                    if (en_destino) begin
                        estado_d = (estado_q == REGRESAR) ? FIN : ASENTAR;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ASENTAR: begin
                if (cnt_q == CW'(TIEMPO_CORTE - 1)) begin
                    cnt_d    = '0;
                    estado_d = AVISAR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            AVISAR: begin
                cnt_d    = '0;
                estado_d = ESPERAR_DATO;
            end
            ESPERAR_DATO: begin
                if (cnt_q == CW'(LATENCIA_DATO - 1)) begin
                    cnt_d    = '0;
                    estado_d = CARGAR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN: begin
                estado_d = FIN;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase

        // Dropping cortando wins over everything, including a step due on this very edge.
        if ((estado_q != REPOSO) && !cortando) begin
            estado_d = REPOSO;
            div_d    = '0;
            cnt_d    = '0;
            x_d      = x_q;
            y_d      = y_q;
            tx_d     = tx_q;
            ty_d     = ty_q;
            dir_x_d  = dir_x_q;
            dir_y_d  = dir_y_q;
            paso_x_d = 1'b0;
            paso_y_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= REPOSO;
            div_q    <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            dir_x_q  <= 1'b0;
            dir_y_q  <= 1'b0;
            paso_x_q <= 1'b0;
            paso_y_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            paso_x_q <= paso_x_d;
            paso_y_q <= paso_y_d;
        end
    end

    assign x_actual        = x_q;
    assign y_actual        = y_q;
    assign paso_x          = paso_x_q;
    assign paso_y          = paso_y_q;
    assign dir_x           = dir_x_q;
    assign dir_y           = dir_y_q;
    assign dato_siguiente  = (estado_q == AVISAR);
    assign corte_terminado = (estado_q == FIN);
    assign en_movimiento   = (estado_q == MOVER) || (estado_q == REGRESAR);
    assign estado_actual   = estado_q;

endmodule
